// File: rtl/spw_tx_arb_pkg.sv
// Shared types and constants for the SpaceWire TX data-character arbiter.
package spw_tx_arb_pkg;

    // Arbiter FSM states; the encoding is exported on arb_state for readback.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        ABORT = 2'd3
    } arb_state_t;

    // 9-bit character encoding: bit8=1 marks a control character.
    localparam logic [8:0] EOP_CHAR = 9'h100;
    localparam logic [8:0] EEP_CHAR = 9'h101;

    // Source indices into the {B,A} vectors.
    localparam int SRC_A = 0;
    localparam int SRC_B = 1;

endpackage

// File: rtl/spw_pkt_discard.sv
// Per-source discard flag: once set, the source is drained (ready forced high)
// until it offers its end-of-packet marker, which clears the flag next cycle.
module spw_pkt_discard
    import spw_tx_arb_pkg::*;
(
    input  logic pclk,
    input  logic reset,
    input  logic i_set,        // abort of this source's packet
    input  logic i_write,      // source valid
    input  logic i_eop_bit,    // bit8 of the source character
    input  logic i_fsm_ready,  // ready from the arbiter FSM
    output logic o_discard,
    output logic o_ready
);

    logic r_discard;

    // Discard flag: set on abort, cleared once the dropped packet's EOP/EEP is accepted.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_discard <= 1'b0;
        end else if (i_set) begin
            r_discard <= 1'b1;
        end else if (r_discard && i_write && i_eop_bit) begin
            r_discard <= 1'b0;
        end
    end

    assign o_discard = r_discard;
    assign o_ready   = r_discard | i_fsm_ready;

endmodule

// File: rtl/spw_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the TX_SPW data-character port
// between source A (host path) and source B (test generator). Stalled packets
// are terminated with an injected EEP; aborted sources drain their remainder.
// Handshake: every interface transfers a character on a cycle where write and
// ready are both high; write does not depend on ready.
module spw_tx_arbiter
    import spw_tx_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       link_run,
    input  logic [8:0] a_data,
    input  logic       a_write,
    output logic       a_ready,
    input  logic [8:0] b_data,
    input  logic       b_write,
    output logic       b_ready,
    output logic [8:0] tx_data,
    output logic       tx_write,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic [1:0] abort_evt,
    output logic [1:0] discard,
    output logic [1:0] arb_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fwd;        // a character of the current packet went out
    logic             r_last;       // last served source index (0=A, 1=B)
    logic [1:0]       r_grant;
    logic [1:0]       r_abort_evt;

    logic             w_own_b;
    logic [8:0]       w_src_data;
    logic             w_src_write;
    logic [1:0]       w_req;
    logic [1:0]       w_discard;
    logic [1:0]       w_set;
    logic [1:0]       w_fsm_ready;
    logic [8:0]       w_tx_data;
    logic             w_tx_write;
    logic             w_xfer;
    logic             w_eop_done;
    logic             w_eep_done;
    logic             w_link_abort;
    logic             w_count;

    assign w_own_b     = (r_state == GNT_B);
    assign w_src_data  = w_own_b ? b_data  : a_data;
    assign w_src_write = w_own_b ? b_write : a_write;
    assign w_req       = {b_write & ~w_discard[SRC_B], a_write & ~w_discard[SRC_A]};

    // Next-state, pass-through datapath and event decode.
    always_comb begin
        w_next       = r_state;
        w_tx_data    = 9'h000;
        w_tx_write   = 1'b0;
        w_fsm_ready  = 2'b00;
        w_xfer       = 1'b0;
        w_eop_done   = 1'b0;
        w_eep_done   = 1'b0;
        w_link_abort = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            IDLE: begin
                if (link_run) begin
                    if (w_req[SRC_A] && w_req[SRC_B]) begin
                        w_next = (r_last == 1'(SRC_A)) ? GNT_B : GNT_A;
                    end else if (w_req[SRC_A]) begin
                        w_next = GNT_A;
                    end else if (w_req[SRC_B]) begin
                        w_next = GNT_B;
                    end
                end
            end
            GNT_A, GNT_B: begin
                if (!link_run) begin
                    w_next       = IDLE;
                    w_link_abort = r_fwd;
                end else begin
                    w_tx_data  = w_src_data;
                    w_tx_write = w_src_write;
                    if (w_own_b) begin
                        w_fsm_ready[SRC_B] = tx_ready;
                    end else begin
                        w_fsm_ready[SRC_A] = tx_ready;
                    end
                    if (w_src_write && tx_ready) begin
                        w_xfer = 1'b1;
                        if (w_src_data[8]) begin
                            w_eop_done = 1'b1;
                            w_next     = IDLE;
                        end
                    end else if (!w_src_write && tx_ready) begin
                        w_count = 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            w_next = ABORT;
                        end
                    end
                end
            end
            ABORT: begin
                if (!link_run) begin
                    w_next       = IDLE;
                    w_link_abort = r_fwd;
                end else begin
                    w_tx_data  = EEP_CHAR;
                    w_tx_write = 1'b1;
                    if (tx_ready) begin
                        w_eep_done = 1'b1;
                        w_next     = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_set = (w_eep_done || w_link_abort) ? r_grant : 2'b00;

    // State, grant, timeout counter and packet bookkeeping registers.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_cnt       <= '0;
            r_fwd       <= 1'b0;
            r_last      <= 1'(SRC_B);
            r_abort_evt <= 2'b00;
        end else begin
            r_state     <= w_next;
            r_abort_evt <= w_set;
            case (w_next)
                GNT_A:   r_grant <= 2'b01;
                GNT_B:   r_grant <= 2'b10;
                ABORT:   r_grant <= r_grant;
                default: r_grant <= 2'b00;
            endcase
            if (r_state != w_next || w_xfer) begin
                r_cnt <= '0;
            end else if (w_count) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == IDLE) begin
                r_fwd <= 1'b0;
            end else if (w_xfer) begin
                r_fwd <= 1'b1;
            end
            if (w_eop_done || w_eep_done) begin
                r_last <= r_grant[SRC_B];
            end
        end
    end

    spw_pkt_discard u_discard_a (
        .pclk        (pclk),
        .reset       (reset),
        .i_set       (w_set[SRC_A]),
        .i_write     (a_write),
        .i_eop_bit   (a_data[8]),
        .i_fsm_ready (w_fsm_ready[SRC_A]),
        .o_discard   (w_discard[SRC_A]),
        .o_ready     (a_ready)
    );

    spw_pkt_discard u_discard_b (
        .pclk        (pclk),
        .reset       (reset),
        .i_set       (w_set[SRC_B]),
        .i_write     (b_write),
        .i_eop_bit   (b_data[8]),
        .i_fsm_ready (w_fsm_ready[SRC_B]),
        .o_discard   (w_discard[SRC_B]),
        .o_ready     (b_ready)
    );

    assign tx_data   = w_tx_data;
    assign tx_write  = w_tx_write;
    assign grant     = r_grant;
    assign abort_evt = r_abort_evt;
    assign discard   = w_discard;
    assign arb_state = r_state;

endmodule

// File: tb/tb_spw_tx_arbiter.sv
// Directed bench for spw_tx_arbiter with TIMEOUT_CYCLES=8.
module tb_spw_tx_arbiter;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       link_run = 1'b0;
    logic [8:0] a_data = 9'h000;
    logic       a_write = 1'b0;
    logic       a_ready;
    logic [8:0] b_data = 9'h000;
    logic       b_write = 1'b0;
    logic       b_ready;
    logic [8:0] tx_data;
    logic       tx_write;
    logic       tx_ready = 1'b0;
    logic [1:0] grant;
    logic [1:0] abort_evt;
    logic [1:0] discard;
    logic [1:0] arb_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_abort_seen = 0;
    logic [8:0] exp_q[$];

    spw_tx_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .pclk      (pclk),
        .reset     (reset),
        .link_run  (link_run),
        .a_data    (a_data),
        .a_write   (a_write),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_write   (b_write),
        .b_ready   (b_ready),
        .tx_data   (tx_data),
        .tx_write  (tx_write),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .abort_evt (abort_evt),
        .discard   (discard),
        .arb_state (arb_state)
    );

    // clock / watchdog
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // scoreboard: every character TX_SPW accepts must be the next expected one
    always @(negedge pclk) begin
        if (!reset && tx_write && tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("tx_unexpected", 16'(exp_q.size()), 16'd1);
            end else begin
                chk("tx_char", 16'(tx_data), 16'(exp_q.pop_front()));
            end
        end
        if (!reset && abort_evt != 2'b00) n_abort_seen++;
    end

    initial begin
        // ---------------- reset values
        tick(); tick();
        chk("rst_grant", 16'(grant), 16'h0);
        chk("rst_state", 16'(arb_state), 16'h0);
        chk("rst_discard", 16'(discard), 16'h0);
        chk("rst_abort", 16'(abort_evt), 16'h0);
        chk("rst_txw", 16'(tx_write), 16'h0);
        chk("rst_txd", 16'(tx_data), 16'h0);
        chk("rst_ardy", 16'(a_ready), 16'h0);
        chk("rst_brdy", 16'(b_ready), 16'h0);
        reset = 1'b0;
        link_run = 1'b1;
        tx_ready = 1'b1;

        // ---------------- T1: single packet from A
        exp_q.push_back(9'h041); exp_q.push_back(9'h042); exp_q.push_back(9'h100);
        a_write = 1'b1; a_data = 9'h041;
        #1 chk("t1_idle_txw", 16'(tx_write), 16'h0);
        tick();
        chk("t1_grant", 16'(grant), 16'h1);
        chk("t1_txd", 16'(tx_data), 16'h041);
        chk("t1_ardy", 16'(a_ready), 16'h1);
        chk("t1_brdy", 16'(b_ready), 16'h0);
        tick(); a_data = 9'h042;
        tick(); a_data = 9'h100;
        tick();
        chk("t1_grant_rel", 16'(grant), 16'h0);
        chk("t1_state_idle", 16'(arb_state), 16'h0);
        a_write = 1'b0;
        #1 chk("t1_txw_idle", 16'(tx_write), 16'h0);

        // ---------------- T2: tie from reset, round robin, no interleave
        reset = 1'b1; tick(); reset = 1'b0;
        exp_q.push_back(9'h011); exp_q.push_back(9'h100);
        exp_q.push_back(9'h021); exp_q.push_back(9'h100);
        exp_q.push_back(9'h012); exp_q.push_back(9'h100);
        a_write = 1'b1; a_data = 9'h011;
        b_write = 1'b1; b_data = 9'h021;
        tick();
        chk("t2_grant_a", 16'(grant), 16'h1);
        #1 chk("t2_brdy_blk", 16'(b_ready), 16'h0);
        tick(); a_data = 9'h100;
        tick(); a_data = 9'h012;
        chk("t2_idle_gap", 16'(grant), 16'h0);
        tick();
        chk("t2_grant_b", 16'(grant), 16'h2);
        #1 chk("t2_ardy_blk", 16'(a_ready), 16'h0);
        tick(); b_data = 9'h100;
        tick(); b_write = 1'b0;
        chk("t2_b_done", 16'(grant), 16'h0);
        tick();
        chk("t2_grant_a2", 16'(grant), 16'h1);
        tick(); a_data = 9'h100;
        tick(); a_write = 1'b0;
        chk("t2_done", 16'(grant), 16'h0);

        // ---------------- T3: B stalls, timeout injects EEP, rest discarded
        exp_q.push_back(9'h0AA); exp_q.push_back(9'h101);
        b_write = 1'b1; b_data = 9'h0AA;
        tick();
        chk("t3_grant_b", 16'(grant), 16'h2);
        tick(); b_write = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t3_waiting", 16'(arb_state), 16'h2);
        end
        tick();
        chk("t3_abort_state", 16'(arb_state), 16'h3);
        chk("t3_abort_grant", 16'(grant), 16'h2);
        chk("t3_eep_data", 16'(tx_data), 16'h101);
        chk("t3_eep_write", 16'(tx_write), 16'h1);
        chk("t3_brdy_abort", 16'(b_ready), 16'h0);
        tick();
        chk("t3_abort_evt", 16'(abort_evt), 16'h2);
        chk("t3_discard", 16'(discard), 16'h2);
        chk("t3_state_idle", 16'(arb_state), 16'h0);
        b_write = 1'b1; b_data = 9'h0BB;
        #1 chk("t3_brdy_drain", 16'(b_ready), 16'h1);
        chk("t3_no_tx", 16'(tx_write), 16'h0);
        tick();
        chk("t3_abort_pulse", 16'(abort_evt), 16'h0);
        chk("t3_no_grant", 16'(grant), 16'h0);
        b_data = 9'h100;
        tick();
        chk("t3_discard_clr", 16'(discard), 16'h0);
        b_write = 1'b0;

        // ---------------- T4: backpressure does not count toward timeout
        n_abort_seen = 0;
        exp_q.push_back(9'h031); exp_q.push_back(9'h032); exp_q.push_back(9'h100);
        a_write = 1'b1; a_data = 9'h031;
        tick();
        tick(); a_write = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        chk("t4_still_granted", 16'(arb_state), 16'h1);
        tx_ready = 1'b1; a_write = 1'b1; a_data = 9'h032;
        tick(); a_data = 9'h100;
        tick(); a_write = 1'b0;
        chk("t4_done", 16'(arb_state), 16'h0);
        chk("t4_no_abort", 16'(n_abort_seen), 16'h0);

        // ---------------- T5: link loss after one character, then before any
        exp_q.push_back(9'h051);
        a_write = 1'b1; a_data = 9'h051;
        tick();
        tick(); link_run = 1'b0; a_data = 9'h052;
        #1 chk("t5_txw_linkdown", 16'(tx_write), 16'h0);
        chk("t5_ardy_linkdown", 16'(a_ready), 16'h0);
        tick();
        chk("t5_state_idle", 16'(arb_state), 16'h0);
        chk("t5_abort_evt", 16'(abort_evt), 16'h1);
        chk("t5_discard", 16'(discard), 16'h1);
        a_data = 9'h100;
        #1 chk("t5_ardy_drain", 16'(a_ready), 16'h1);
        tick(); a_write = 1'b0;
        chk("t5_discard_clr", 16'(discard), 16'h0);
        link_run = 1'b1; tx_ready = 1'b0;
        a_write = 1'b1; a_data = 9'h061;
        tick();
        chk("t5b_grant", 16'(grant), 16'h1);
        link_run = 1'b0;
        tick();
        chk("t5b_state_idle", 16'(arb_state), 16'h0);
        chk("t5b_no_abort", 16'(abort_evt), 16'h0);
        chk("t5b_no_discard", 16'(discard), 16'h0);
        a_write = 1'b0; link_run = 1'b1; tx_ready = 1'b1;

        // ---------------- T6: reset while in ABORT
        exp_q.push_back(9'h071);
        a_write = 1'b1; a_data = 9'h071;
        tick();
        tick(); a_write = 1'b0;
        for (int i = 0; i < 20 && arb_state != 2'd3; i++) tick();
        tx_ready = 1'b0;
        chk("t6_in_abort", 16'(arb_state), 16'h3);
        reset = 1'b1;
        tick();
        chk("t6_grant", 16'(grant), 16'h0);
        chk("t6_state", 16'(arb_state), 16'h0);
        chk("t6_discard", 16'(discard), 16'h0);
        chk("t6_abort", 16'(abort_evt), 16'h0);
        chk("t6_txw", 16'(tx_write), 16'h0);
        chk("t6_txd", 16'(tx_data), 16'h0);
        reset = 1'b0; tx_ready = 1'b1;
        tick(); tick();

        // ---------------- final report
        chk("exp_q_drained", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
